pcgen: RTL and testbench

Program counter generator for the front end. It sits directly upstream of the instruction fetch unit:
- it observes the PC currently being fetched;
- it offers the next fetch PC, either sequential or predicted by a small direct-mapped branch target buffer (BTB);
- it takes control-flow redirects from the back end and raises `invalidate` toward the fetch-to-decode pipeline register until wrong-path instructions are flushed.

---
 rtl/offnariscv_pkg.sv | 20 ++
 rtl/axis_if.sv | 12 +
 rtl/pcgen_btb.sv | 55 +++++
 rtl/pcgen.sv | 99 +++++++++
 tb/tb_pcgen.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/offnariscv_pkg.sv
// Shared types for the offnariscv front end.
// Holds the redirect bundle and the PC generator state encoding.
package offnariscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            flush;
        logic            btb_we;
        logic [XLEN-1:0] src_pc;
        logic [XLEN-1:0] target;
    } redirect_tdata_t;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN
    } pcgen_state_e;

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream interface.
// The m side drives payload and valid, the s side drives ready.
interface axis_if #(
    parameter int W = 32
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pcgen_btb.sv
// Direct-mapped branch target buffer.
// Lookup is combinational; writes become visible the following cycle.
module pcgen_btb
    import offnariscv_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [XLEN-1:0] hit_target,
    input  logic            we,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tags [BTB_ENTRIES];
    logic [XLEN-1:0]        tgts [BTB_ENTRIES];

    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic [TAG_W-1:0] rtag;
    logic [TAG_W-1:0] wtag;
    logic             unused;

    assign ridx   = lookup_pc[IDX_W+1:2];
    assign rtag   = lookup_pc[XLEN-1:IDX_W+2];
    assign widx   = pc[IDX_W+1:2];
    assign wtag   = pc[XLEN-1:IDX_W+2];
    assign unused = ^{lookup_pc[1:0], pc[1:0]};

    assign hit        = valid[ridx] && (tags[ridx] == rtag);
    assign hit_target = tgts[ridx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    // Payload arrays need no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[widx] <= wtag;
            tgts[widx] <= target;
        end
    end

endmodule

// File: rtl/pcgen.sv
// Next-PC generator: sequential/BTB prediction plus redirect handling.
// Raises invalidate while wrong-path fetches are being flushed.
module pcgen
    import offnariscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic clk,
    input  logic rst_n,
    axis_if.s    current_pc_axis_if,
    axis_if.m    next_pc_axis_if,
    axis_if.s    redirect_axis_if,
    output logic invalidate
);
    pcgen_state_e    state_q;
    pcgen_state_e    state_d;
    logic [XLEN-1:0] tgt_q;
    logic [XLEN-1:0] tgt_d;
    logic            invalidate_q;

    redirect_tdata_t redir;
    logic            redir_fire;
    logic            flush_req;
    logic            next_fire;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] pred_pc;
    logic            nvalid;
    logic [XLEN-1:0] ndata;

    assign redir      = redirect_tdata_t'(redirect_axis_if.tdata);
    assign redir_fire = redirect_axis_if.tvalid;
    assign flush_req  = redir_fire && redir.flush;
    assign next_fire  = nvalid && next_pc_axis_if.tready;

    assign current_pc_axis_if.tready = 1'b1;
    assign redirect_axis_if.tready   = 1'b1;
    assign next_pc_axis_if.tvalid    = nvalid;
    assign next_pc_axis_if.tdata     = ndata;
    assign invalidate                = invalidate_q;

    pcgen_btb #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_pc (current_pc_axis_if.tdata),
        .hit       (btb_hit),
        .hit_target(btb_target),
        .we        (redir_fire && redir.btb_we),
        .pc        (redir.src_pc),
        .target    (redir.target)
    );

    assign pred_pc = btb_hit ? btb_target
                             : current_pc_axis_if.tdata + XLEN'(4);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        nvalid  = 1'b0;
        ndata   = pred_pc;
        unique case (state_q)
            RUN: begin
                nvalid = current_pc_axis_if.tvalid;
            end
            FLUSH: begin
                nvalid = 1'b1;
                ndata  = tgt_q;
                if (next_fire) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // A newer redirect always wins, even over a same-cycle handshake.
        if (flush_req) begin
            state_d = FLUSH;
            tgt_d   = redir.target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            tgt_q        <= RESET_VECTOR;
            invalidate_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            invalidate_q <= (state_d != RUN);
        end
    end

endmodule

// File: tb/tb_pcgen.sv
// Self-checking bench for pcgen: vector table through a scoreboard
// queue, plus hand sequences for reset state and reset mid-flush.
module tb_pcgen;
    import offnariscv_pkg::*;

    localparam int RW = $bits(redirect_tdata_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_if #(.W(XLEN)) cur ();
    axis_if #(.W(XLEN)) nxt ();
    axis_if #(.W(RW))   red ();
    logic invalidate;

    pcgen dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .current_pc_axis_if(cur.s),
        .next_pc_axis_if   (nxt.m),
        .redirect_axis_if  (red.s),
        .invalidate        (invalidate)
    );

    typedef struct {
        logic [31:0] pc;
        logic        cv;
        logic        rdy;
        logic        rv;
        logic        rfl;
        logic        rwe;
        logic [31:0] rsrc;
        logic [31:0] rtgt;
        logic [31:0] e_data;
        logic        e_valid;
        logic        e_inv;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        inv;
        logic        chk_data;
        int          id;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        redirect_tdata_t r;
        r.flush  = v.rfl;
        r.btb_we = v.rwe;
        r.src_pc = v.rsrc;
        r.target = v.rtgt;
        cur.tdata  = v.pc;
        cur.tvalid = v.cv;
        nxt.tready = v.rdy;
        red.tvalid = v.rv;
        red.tdata  = r;
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        drive(v);
        e.data     = v.e_data;
        e.valid    = v.e_valid;
        e.inv      = v.e_inv;
        e.chk_data = v.chk_data;
        e.id       = id;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        if (e.chk_data)
            check($sformatf("v%0d tdata", e.id), nxt.tdata, e.data);
        check($sformatf("v%0d tvalid", e.id), 32'(nxt.tvalid), 32'(e.valid));
        check($sformatf("v%0d inv", e.id), 32'(invalidate), 32'(e.inv));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [31:0] pc, logic cv, logic rdy,
                                logic rv, logic rfl, logic rwe,
                                logic [31:0] rsrc, logic [31:0] rtgt,
                                logic [31:0] ed, logic ev, logic ei,
                                logic cd);
        vec_t v;
        v.pc = pc; v.cv = cv; v.rdy = rdy;
        v.rv = rv; v.rfl = rfl; v.rwe = rwe;
        v.rsrc = rsrc; v.rtgt = rtgt;
        v.e_data = ed; v.e_valid = ev; v.e_inv = ei; v.chk_data = cd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(mk(32'h1000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst inv", 32'(invalidate), 32'd0);
        check("rst cur_tready", 32'(cur.tready), 32'd1);
        check("rst red_tready", 32'(red.tready), 32'd1);
        check("rst tvalid", 32'(nxt.tvalid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //          pc           cv rdy rv fl we src      tgt       exp_d     ev ei cd
        tbl.push_back(mk(32'h1000,     1,1, 0,0,0, 0,       0,        32'h1004, 1,0,1));
        tbl.push_back(mk(32'h1000,     0,1, 0,0,0, 0,       0,        32'h1004, 0,0,1));
        tbl.push_back(mk(32'hFFFFFFFC, 1,1, 0,0,0, 0,       0,        32'h0,    1,0,1));
        tbl.push_back(mk(32'h1004,     1,1, 1,1,0, 0,       32'h2000, 32'h1008, 1,0,1));
        tbl.push_back(mk(32'h1008,     1,0, 0,0,0, 0,       0,        32'h2000, 1,1,1));
        tbl.push_back(mk(32'h1008,     1,1, 0,0,0, 0,       0,        32'h2000, 1,1,1));
        tbl.push_back(mk(32'h100C,     1,1, 0,0,0, 0,       0,        0,        0,1,0));
        tbl.push_back(mk(32'h2000,     1,1, 0,0,0, 0,       0,        32'h2004, 1,0,1));
        tbl.push_back(mk(32'h2004,     1,1, 1,0,1, 32'h1008,32'h3000, 32'h2008, 1,0,1));
        tbl.push_back(mk(32'h1008,     1,1, 0,0,0, 0,       0,        32'h3000, 1,0,1));
        tbl.push_back(mk(32'h1048,     1,1, 0,0,0, 0,       0,        32'h104C, 1,0,1));
        tbl.push_back(mk(32'h1008,     1,1, 1,1,0, 0,       32'h2000, 32'h3000, 1,0,1));
        tbl.push_back(mk(32'h300C,     1,0, 1,1,0, 0,       32'h4000, 32'h2000, 1,1,1));
        tbl.push_back(mk(32'h300C,     1,0, 0,0,0, 0,       0,        32'h4000, 1,1,1));
        tbl.push_back(mk(32'h300C,     1,1, 0,0,0, 0,       0,        32'h4000, 1,1,1));
        tbl.push_back(mk(32'h3010,     1,1, 0,0,0, 0,       0,        0,        0,1,0));
        tbl.push_back(mk(32'h1008,     1,1, 0,0,0, 0,       0,        32'h3000, 1,0,1));
        tbl.push_back(mk(32'h1000,     1,1, 1,1,0, 0,       32'h5000, 32'h1004, 1,0,1));
        tbl.push_back(mk(32'h1004,     1,1, 1,1,0, 0,       32'h6000, 32'h5000, 1,1,1));
        tbl.push_back(mk(32'h5000,     1,1, 0,0,0, 0,       0,        32'h6000, 1,1,1));
        tbl.push_back(mk(32'h6000,     1,1, 1,1,0, 0,       32'h7000, 0,        0,1,0));
        tbl.push_back(mk(32'h6004,     1,1, 0,0,0, 0,       0,        32'h7000, 1,1,1));
        tbl.push_back(mk(32'h7000,     1,1, 0,0,0, 0,       0,        0,        0,1,0));
        tbl.push_back(mk(32'h1000,     1,1, 1,0,0, 32'h1000,32'h9000, 32'h1004, 1,0,1));
        tbl.push_back(mk(32'h1000,     1,1, 0,0,0, 0,       0,        32'h1004, 1,0,1));
        tbl.push_back(mk(32'h1008,     1,1, 0,0,0, 0,       0,        32'h3000, 1,0,1));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset while in FLUSH discards the target and empties the BTB.
        apply(mk(32'h1000, 1,1, 1,1,0, 0, 32'h8000, 32'h1004, 1,0,1), 100);
        rst_n = 1'b0;
        apply(mk(32'h1000, 1,0, 0,0,0, 0, 0, 32'h8000, 1,1,1), 101);
        rst_n = 1'b1;
        apply(mk(32'h1008, 1,1, 0,0,0, 0, 0, 32'h100C, 1,0,1), 102);
        apply(mk(32'h100C, 1,1, 0,0,0, 0, 0, 32'h1010, 1,0,1), 103);

        check("sb empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
